// File: rtl/win_pkg.sv
// rtl/win_pkg.sv - shared pixel/width defaults, FSM states and 3x3 window slot indices
package win_pkg;

    localparam int PIX_W = 8;
    localparam int MAX_W = 640;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_RUN   = 2'd2,
        ST_DRAIN = 2'd3
    } win_state_e;

    // Row-major slot numbering: top row 0..2, middle 3..5, bottom 6..8
    localparam int SLOT_TL = 0;
    localparam int SLOT_TC = 1;
    localparam int SLOT_TR = 2;
    localparam int SLOT_ML = 3;
    localparam int SLOT_MC = 4;
    localparam int SLOT_MR = 5;
    localparam int SLOT_BL = 6;
    localparam int SLOT_BC = 7;
    localparam int SLOT_BR = 8;

endpackage

// File: rtl/line_ram.sv
// rtl/line_ram.sv - simple dual-port line buffer, one write and one registered read per cycle
module line_ram #(
    parameter int DEPTH = 640,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [WIDTH-1:0]         rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/window_3x3_gen.sv
// rtl/window_3x3_gen.sv - streaming 3x3 interior window generator over raster pixels
// Optional frame_cnt/err_sof statistics ports when WIN_STAT_EN is defined.
module window_3x3_gen #(
    parameter int MAX_W = win_pkg::MAX_W,
    parameter int PIX_W = win_pkg::PIX_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic [PIX_W-1:0]   s_data,
    input  logic               s_sof,
    input  logic [9:0]         cfg_width,
    input  logic [9:0]         cfg_height,
    output logic               m_valid,
    input  logic               m_ready,
    output logic [9*PIX_W-1:0] m_win,
    output logic               m_sof,
    output logic               m_eol,
    output logic               m_last
`ifdef WIN_STAT_EN
    ,
    output logic [15:0]        frame_cnt,
    output logic [0:0]         err_sof
`endif
);

    import win_pkg::*;

    localparam int         AW      = $clog2(MAX_W);
    localparam logic [9:0] MAX_W10 = 10'(MAX_W);

    win_state_e         state_q;
    logic [9:0]         col_q, row_q, w_q, h_q;
    logic [9:0]         col_d;
    logic [PIX_W-1:0]   win_q [9];
    logic [PIX_W-1:0]   win_d [9];
    logic [9*PIX_W-1:0] win_flat;
    logic [9*PIX_W-1:0] m_win_q;
    logic               m_valid_q, m_sof_q, m_eol_q, m_last_q;
    logic [PIX_W-1:0]   line1_rd, line2_rd;

    logic in_frame, accept, start, cfg_ok, frame_px, px_take, last_col, emit;

    assign in_frame = (state_q == ST_FILL) || (state_q == ST_RUN);
    assign accept   = s_valid & s_ready;
    assign start    = accept & s_sof;
    assign cfg_ok   = (cfg_width >= 10'd3) && (cfg_width <= MAX_W10) && (cfg_height >= 10'd3);
    assign frame_px = accept & in_frame & ~s_sof;
    assign px_take  = (start & cfg_ok) | frame_px;
    assign last_col = (col_q == w_q - 10'd1);
    assign emit     = frame_px && (col_q >= 10'd2) && (row_q >= 10'd2);

    always_comb begin
        case (state_q)
            ST_IDLE:  s_ready = 1'b1;
            ST_DRAIN: s_ready = 1'b0;
            default:  s_ready = ~m_valid_q | m_ready;
        endcase
    end

    // The RAM read address tracks the column of the next pixel so its data is ready on arrival
    always_comb begin
        col_d = col_q;
        if (start) begin
            col_d = 10'd1;
        end else if (frame_px) begin
            col_d = last_col ? 10'd0 : col_q + 10'd1;
        end
    end

    // line1 holds row y-1, line2 holds row y-2; line1's old value cascades into line2
    line_ram #(.DEPTH(MAX_W), .WIDTH(PIX_W)) u_line1 (
        .clk     (clk),
        .wr_en   (px_take),
        .wr_addr (start ? '0 : col_q[AW-1:0]),
        .wr_data (s_data),
        .rd_addr (col_d[AW-1:0]),
        .rd_data (line1_rd)
    );

    line_ram #(.DEPTH(MAX_W), .WIDTH(PIX_W)) u_line2 (
        .clk     (clk),
        .wr_en   (px_take),
        .wr_addr (start ? '0 : col_q[AW-1:0]),
        .wr_data (line1_rd),
        .rd_addr (col_d[AW-1:0]),
        .rd_data (line2_rd)
    );

    always_comb begin
        win_d          = win_q;
        win_d[SLOT_TL] = win_q[SLOT_TC];
        win_d[SLOT_TC] = win_q[SLOT_TR];
        win_d[SLOT_TR] = line2_rd;
        win_d[SLOT_ML] = win_q[SLOT_MC];
        win_d[SLOT_MC] = win_q[SLOT_MR];
        win_d[SLOT_MR] = line1_rd;
        win_d[SLOT_BL] = win_q[SLOT_BC];
        win_d[SLOT_BC] = win_q[SLOT_BR];
        win_d[SLOT_BR] = s_data;
        win_flat       = '0;
        for (int k = 0; k < 9; k++) begin
            win_flat[PIX_W*k +: PIX_W] = win_d[k];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            col_q     <= '0;
            row_q     <= '0;
            w_q       <= '0;
            h_q       <= '0;
            m_valid_q <= 1'b0;
            m_sof_q   <= 1'b0;
            m_eol_q   <= 1'b0;
            m_last_q  <= 1'b0;
            m_win_q   <= '0;
            for (int k = 0; k < 9; k++) begin
                win_q[k] <= '0;
            end
        end else begin
            col_q <= col_d;
            if (px_take) begin
                win_q <= win_d;
            end

            if (start) begin
                w_q     <= cfg_width;
                h_q     <= cfg_height;
                row_q   <= '0;
                state_q <= cfg_ok ? ST_FILL : ST_IDLE;
            end else if (frame_px) begin
                if (last_col) begin
                    row_q <= row_q + 10'd1;
                    if (state_q == ST_FILL && row_q == 10'd1) begin
                        state_q <= ST_RUN;
                    end
                    if (state_q == ST_RUN && row_q == h_q - 10'd1) begin
                        state_q <= ST_DRAIN;
                    end
                end
            end else if (state_q == ST_DRAIN && m_valid_q && m_ready && m_last_q) begin
                state_q <= ST_IDLE;
            end

            // A new window only lands when the slot is free or being consumed this cycle
            if (emit) begin
                m_valid_q <= 1'b1;
                m_win_q   <= win_flat;
                m_sof_q   <= (col_q == 10'd2) && (row_q == 10'd2);
                m_eol_q   <= last_col;
                m_last_q  <= last_col && (row_q == h_q - 10'd1);
            end else if (m_ready) begin
                m_valid_q <= 1'b0;
                m_sof_q   <= 1'b0;
                m_eol_q   <= 1'b0;
                m_last_q  <= 1'b0;
            end
        end
    end

    assign m_valid = m_valid_q;
    assign m_win   = m_win_q;
    assign m_sof   = m_sof_q;
    assign m_eol   = m_eol_q;
    assign m_last  = m_last_q;

`ifdef WIN_STAT_EN
    logic [15:0] frame_cnt_q;
    logic        err_sof_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt_q <= '0;
            err_sof_q   <= 1'b0;
        end else begin
            if (m_valid_q && m_ready && m_last_q) begin
                frame_cnt_q <= frame_cnt_q + 16'd1;
            end
            err_sof_q <= start & in_frame;
        end
    end

    assign frame_cnt  = frame_cnt_q;
    assign err_sof[0] = err_sof_q;
`endif

endmodule

// File: tb/tb_window_3x3_gen.sv
// tb/tb_window_3x3_gen.sv - randomized bench for window_3x3_gen against a frame-level window model
module tb_window_3x3_gen;

    localparam int PIX_W = 8;
    localparam int MAX_W = 640;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               s_valid = 1'b0;
    logic               s_ready;
    logic [PIX_W-1:0]   s_data = '0;
    logic               s_sof = 1'b0;
    logic [9:0]         cfg_width = '0;
    logic [9:0]         cfg_height = '0;
    logic               m_valid;
    logic               m_ready = 1'b0;
    logic [9*PIX_W-1:0] m_win;
    logic               m_sof, m_eol, m_last;
`ifdef WIN_STAT_EN
    logic [15:0]        frame_cnt;
    logic [0:0]         err_sof;
`endif

    always #5 clk = ~clk;

    window_3x3_gen #(.MAX_W(MAX_W), .PIX_W(PIX_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .s_sof      (s_sof),
        .cfg_width  (cfg_width),
        .cfg_height (cfg_height),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_win      (m_win),
        .m_sof      (m_sof),
        .m_eol      (m_eol),
        .m_last     (m_last)
`ifdef WIN_STAT_EN
        ,
        .frame_cnt  (frame_cnt),
        .err_sof    (err_sof)
`endif
    );

    typedef struct {
        logic [9*PIX_W-1:0] win;
        logic               sof;
        logic               eol;
        logic               last;
    } exp_t;

    exp_t             exp_q [$];
    logic [PIX_W-1:0] pix_buf [0:4095];
    int               n_total = 0;
    int               n_bad = 0;
    int               exp_frames = 0;
    int               n_err_pulses = 0;
    logic             prev_stall = 1'b0;
    logic [9*PIX_W-1:0] prev_win;
    logic [2:0]       prev_flags;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] want);
        n_total++;
        if (obs !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, want);
        end
    endtask

    // Output monitor: scoreboard pops on every handshake and checks hold behaviour under back-pressure
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (prev_stall) begin
                check("hold_valid", 128'(m_valid), 128'd1);
                check("hold_win", 128'(m_win), 128'(prev_win));
                check("hold_flags", 128'({m_sof, m_eol, m_last}), 128'(prev_flags));
            end
            if (m_valid && !m_ready) check("sready_stall", 128'(s_ready), 128'd0);
            if (!m_valid) check("flags_idle", 128'({m_sof, m_eol, m_last}), 128'd0);
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    check("extra_window", 128'(exp_q.size()), 128'd1);
                end else begin
                    e = exp_q.pop_front();
                    check("win", 128'(m_win), 128'(e.win));
                    check("sof", 128'(m_sof), 128'(e.sof));
                    check("eol", 128'(m_eol), 128'(e.eol));
                    check("last", 128'(m_last), 128'(e.last));
                    if (e.last) exp_frames++;
                end
            end
            prev_stall = m_valid && !m_ready;
            prev_win   = m_win;
            prev_flags = {m_sof, m_eol, m_last};
        end else begin
            prev_stall = 1'b0;
        end
`ifdef WIN_STAT_EN
        if (err_sof[0]) n_err_pulses++;
`endif
    end

    // Sends n pixels of a w x h frame (n < w*h aborts it) and queues the interior windows
    // whose bottom-right pixel is among those sent.
    task automatic run_frame(input int w, input int h, input int n, input int rdy_pct,
                             input bit gaps, input bit seq, input bit stall_first);
        exp_t e;
        bit   ok;
        bit   lat_pend;
        int   i, guard, budget, stall_left;
        ok = (w >= 3) && (w <= MAX_W) && (h >= 3);
        for (int p = 0; p < n; p++) pix_buf[p] = seq ? PIX_W'(p) : PIX_W'($urandom);
        if (ok) begin
            for (int y = 1; y <= h - 2; y++) begin
                for (int x = 1; x <= w - 2; x++) begin
                    if ((y + 1) * w + x + 1 < n) begin
                        e.win = '0;
                        for (int k = 0; k < 9; k++)
                            e.win[PIX_W*k +: PIX_W] = pix_buf[(y - 1 + k / 3) * w + (x - 1 + k % 3)];
                        e.sof  = (x == 1) && (y == 1);
                        e.eol  = (x == w - 2);
                        e.last = (x == w - 2) && (y == h - 2);
                        exp_q.push_back(e);
                    end
                end
            end
        end
        i = 0; guard = 0; lat_pend = 0; stall_left = stall_first ? 5 : 0;
        budget = n * 30 + 200;
        while (i < n) begin
            @(posedge clk); #1;
            if (stall_left > 0 && m_valid) begin
                m_ready = 1'b0;
                stall_left--;
            end else begin
                m_ready = ($urandom_range(0, 99) < rdy_pct);
            end
            s_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            s_data  = pix_buf[i];
            s_sof   = (i == 0);
            cfg_width  = (i == 0) ? 10'(w) : 10'($urandom);
            cfg_height = (i == 0) ? 10'(h) : 10'($urandom);
            @(negedge clk);
            if (lat_pend) check("latency", 128'(m_valid), 128'd1);
            lat_pend = 0;
            if (!ok) begin
                check("bad_cfg_sready", 128'(s_ready), 128'd1);
                check("bad_cfg_mvalid", 128'(m_valid), 128'd0);
            end
            if (s_valid && s_ready) begin
                if (ok && (i % w) >= 2 && (i / w) >= 2) lat_pend = 1;
                i++;
            end
            guard++;
            if (guard >= budget) begin
                check("tx_timeout", 128'(i), 128'(n));
                break;
            end
        end
        @(posedge clk); #1;
        s_valid = 1'b0;
        s_sof   = 1'b0;
        m_ready = ($urandom_range(0, 99) < rdy_pct);
        @(negedge clk);
        if (lat_pend) check("latency", 128'(m_valid), 128'd1);
    endtask

    task automatic drain(input int budget);
        int c;
        c = 0;
        while (exp_q.size() != 0 && c < budget) begin
            @(posedge clk); #1;
            s_valid = 1'b0;
            m_ready = 1'b1;
            c++;
        end
        @(posedge clk); #1;
        check("drain_empty", 128'(exp_q.size()), 128'd0);
    endtask

    initial begin
        int w, h;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_mvalid", 128'(m_valid), 128'd0);
        check("rst_mwin", 128'(m_win), 128'd0);
        check("rst_flags", 128'({m_sof, m_eol, m_last}), 128'd0);
        check("rst_sready", 128'(s_ready), 128'd1);
`ifdef WIN_STAT_EN
        check("rst_frame_cnt", 128'(frame_cnt), 128'd0);
`endif

        // 4x4 ramp, always ready
        run_frame(4, 4, 16, 100, 0, 1, 0);
        drain(200);

        // 5x5 with the first window held for 5 cycles
        run_frame(5, 5, 25, 100, 0, 0, 1);
        drain(200);

        // 5x5 restarted by a new sof on its 8th pixel
        run_frame(5, 5, 7, 100, 0, 0, 0);
        run_frame(5, 5, 25, 100, 0, 0, 0);
        drain(200);

        // random sizes, random gaps and back-pressure
        for (int f = 0; f < 4; f++) begin
            w = $urandom_range(3, 9);
            h = $urandom_range(3, 6);
            run_frame(w, h, w * h, 60, 1, 0, 0);
        end
        drain(500);

        // width 2 is rejected: everything discarded
        run_frame(2, 4, 8, 100, 0, 0, 0);
        drain(50);

        // reset in the middle of a RUN row, then stray pixels, then a clean frame
        run_frame(6, 5, 16, 100, 0, 0, 0);
        drain(200);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("midrst_mvalid", 128'(m_valid), 128'd0);
        check("midrst_mwin", 128'(m_win), 128'd0);
        for (int p = 0; p < 6; p++) begin
            @(posedge clk); #1;
            s_valid = 1'b1;
            s_sof   = 1'b0;
            s_data  = PIX_W'($urandom);
            m_ready = 1'b1;
            @(negedge clk);
            check("drop_sready", 128'(s_ready), 128'd1);
            check("drop_mvalid", 128'(m_valid), 128'd0);
        end
        @(posedge clk); #1;
        s_valid = 1'b0;
        exp_frames = 0;
        run_frame(6, 4, 24, 80, 1, 0, 0);
        drain(200);

        // full-width three-line frame, continuous input
        run_frame(640, 3, 1920, 100, 0, 0, 0);
        drain(2000);
`ifdef WIN_STAT_EN
        check("frame_cnt", 128'(frame_cnt), 128'(exp_frames));
        check("err_sof_pulses", 128'(n_err_pulses), 128'd1);
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
